cpu_clock_gen: RTL
==================

Name: cpu_clock_gen

Overview:
Clock-enable and reset sequencer that sits directly upstream of the FPGA top level. From the single 12.5875 MHz pixel clock it generates:
- the CPU clock enable and the phi2 pin clock;
- the controller shift-clock enable, which is a subset of the CPU enables;
- the system reset (active-high) and the 6502 reset (active-low).

It also provides a halt/single-step debug gate that freezes the CPU clock domain cleanly at a phase boundary.

Parameters:
CPU_DIV, 4, pixel clocks per CPU cycle; must be even and >=2 (elaboration error otherwise).
CTRL_DIV, 64, CPU enables per controller_clk_in_enable; must be >=1.
RST_HOLD, 16, pixel clocks that rst is held after synchronized rst_B release.
CPU_RES_EXTRA, 8, CPU enables that cpu_res_B is held low after rst deasserts; must be >=2.

Ports:
clk_12_5875  input  1  pixel clock; the only clock in this block.
rst_B  input  1  asynchronous, active-low reset.
halt  input  1  debug freeze request; level-sensitive, synchronous to clk_12_5875.
step  input  1  single-step request; rising edge detected internally.
cpu_clk_enable  output  1  one-cycle pulse, once per CPU cycle.
phi2  output  1  registered CPU phase-2 clock for the 6502 pin.
controller_clk_in_enable  output  1  one-cycle pulse, every CTRL_DIV CPU enables.
rst  output  1  active-high system reset; asynchronous assert, synchronous deassert.
cpu_res_B  output  1  6502 reset, active low.
running  output  1  high while the divider is advancing.

Behaviour:
- Reset is asynchronous and active-low; the clock is clk_12_5875 (single clock domain). While rst_B=0, with no clock edge needed:
  - rst=1, cpu_res_B=0;
  - cpu_clk_enable=0, controller_clk_in_enable=0, phi2=0, running=0;
  - all counters 0; the step-pending flag and the step edge-detect register are cleared.
- Reset sequencer:
  - rst_B passes through a 2-flop synchronizer.
  - A hold counter then counts RST_HOLD edges.
  - rst goes to 0 on the (RST_HOLD+2)th rising edge after the first edge that samples rst_B=1.
- Divider:
  - div_cnt is $clog2(CPU_DIV) bits and is held at 0 while rst=1.
  - Otherwise it counts 0..CPU_DIV-1 and wraps.
  - phi2 is registered and is 1 exactly while div_cnt >= CPU_DIV/2.
  - cpu_clk_enable=1 exactly in the cycle where div_cnt==CPU_DIV-1 (last phi2-high cycle), so the CPU domain latches at phi2 fall.
- Halt gate:
  - The gate decision is taken only when div_cnt==0.
  - If halt=1 and step_pending=0, div_cnt holds at 0: phi2=0, no enables, running=0.
  - Assertion of halt mid-period never truncates that period; the current CPU cycle always completes.
  - Deasserting halt resumes counting on the next edge.
- Step:
  - A step rising edge sets step_pending only if halt=1 and div_cnt is held at 0.
  - Step edges while running, or during an in-progress step period, are ignored.
  - When held at 0 with step_pending=1, the divider runs exactly one full period and step_pending clears on leaving 0.
  - Result: exactly one cpu_clk_enable per accepted step.
- running = !rst && !(div_cnt==0 && halt && !step_pending).
- Controller enable:
  - ctrl_cnt is $clog2(CTRL_DIV) bits (1 bit if CTRL_DIV=1) and increments on each cpu_clk_enable, wrapping at CTRL_DIV-1.
  - controller_clk_in_enable = cpu_clk_enable && ctrl_cnt==CTRL_DIV-1; it is always coincident with a CPU enable.
  - Halt freezes ctrl_cnt; its value is preserved across halt.
- cpu_res_B:
  - After rst deasserts, count cpu_clk_enable pulses.
  - cpu_res_B rises on the edge ending the CPU_RES_EXTRA-th pulse and stays 1 until reset.
  - Halt stalls this count.
- Reset mid-operation: rst_B low at any phase (mid-step, mid-halt, mid-sequence) immediately forces the reset values above; no pending state survives.
- No output glitches: every output except the asynchronous reset path is driven directly from a flop.

Test Plan:
- Reset release with default parameters: rst_B 0->1 before edge 0 → rst=1 through edge 17 and 0 after edge 18; phi2 pattern thereafter 0,0,1,1 repeating; first cpu_clk_enable in the 4th cycle after rst falls, then every 4 cycles.
- CPU reset hold: from the first enable, count 8 pulses → cpu_res_B=0 until the edge ending pulse 8 (32 clocks after rst falls), then 1 permanently.
- Controller cadence: run 1024 clocks after rst falls → exactly 4 controller_clk_in_enable pulses, 256 clocks apart, each coincident with cpu_clk_enable.
- Halt and step: assert halt when div_cnt==2 → that period completes (one more enable), then phi2=0 and running=0 for 100 cycles. Then step pulses at t and t+1 → exactly one cpu_clk_enable and one 0011 phi2 sequence; ctrl_cnt advances by 1.
- Step while running: halt=0, 10 step pulses → enable spacing unchanged (every 4 clocks), no extra pulses. A subsequent halt freezes at div_cnt=0 with step_pending=0.
- Asynchronous reset mid-step: drop rst_B between edges while div_cnt==2 in a step period → rst=1, cpu_res_B=0, phi2=0, running=0 immediately. After release the full 18-clock sequence replays, and no residual step occurs under halt=1.

Source files
------------

// File: rtl/cpu_clock_gen_if.sv
// Debug controls into, and clock enables / resets out of, the CPU clock generator.
interface cpu_clock_gen_if;
  logic halt;
  logic step;
  logic cpu_clk_enable;
  logic phi2;
  logic controller_clk_in_enable;
  logic rst;
  logic cpu_res_B;
  logic running;

  modport master (
    input  halt,
    input  step,
    output cpu_clk_enable,
    output phi2,
    output controller_clk_in_enable,
    output rst,
    output cpu_res_B,
    output running
  );

  modport slave (
    output halt,
    output step,
    input  cpu_clk_enable,
    input  phi2,
    input  controller_clk_in_enable,
    input  rst,
    input  cpu_res_B,
    input  running
  );
endinterface

// File: rtl/cpu_clock_gen.sv
// CPU clock-enable / phi2 generator and reset sequencer driven by the pixel clock,
// with a halt / single-step gate that only freezes the CPU at a period boundary.
module cpu_clock_gen #(
  parameter int CPU_DIV       = 4,
  parameter int CTRL_DIV      = 64,
  parameter int RST_HOLD      = 16,
  parameter int CPU_RES_EXTRA = 8
) (
  input  logic            clk_12_5875,
  input  logic            rst_B,
  cpu_clock_gen_if.master bus
);
  localparam int DW = $clog2(CPU_DIV);
  localparam int CW = (CTRL_DIV > 1) ? $clog2(CTRL_DIV) : 1;
  localparam int HW = (RST_HOLD > 0) ? $clog2(RST_HOLD + 1) : 1;
  localparam int RW = $clog2(CPU_RES_EXTRA + 1);

  localparam logic [DW-1:0] DIV_LAST  = DW'(CPU_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF  = DW'(CPU_DIV / 2);
  localparam logic [CW-1:0] CTRL_LAST = CW'(CTRL_DIV - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(RST_HOLD);
  localparam logic [RW-1:0] RES_MAX   = RW'(CPU_RES_EXTRA);

  if ((CPU_DIV < 2) || ((CPU_DIV % 2) != 0)) begin : g_bad_cpu_div
    $error("cpu_clock_gen: CPU_DIV must be even and >= 2");
  end
  if (CTRL_DIV < 1) begin : g_bad_ctrl_div
    $error("cpu_clock_gen: CTRL_DIV must be >= 1");
  end
  if (CPU_RES_EXTRA < 2) begin : g_bad_res_extra
    $error("cpu_clock_gen: CPU_RES_EXTRA must be >= 2");
  end

  logic [1:0]    sync_r;
  logic [HW-1:0] hold_cnt_r, hold_next_s;
  logic          rst_r, rst_next_s;
  logic [DW-1:0] div_cnt_r, div_next_s;
  logic          step_d_r, step_rise_s, stall_s;
  logic          step_pending_r, pending_next_s;
  logic [CW-1:0] ctrl_cnt_r, ctrl_next_s;
  logic [RW-1:0] res_cnt_r, res_next_s;
  logic          en_r, en_next_s;
  logic          phi2_r, phi2_next_s;
  logic          ctrl_en_r, ctrl_en_next_s;
  logic          cpu_res_b_r, cpu_res_b_next_s;
  logic          running_r, running_next_s;

  // Next-state logic; outputs are registered from next state so each flop
  // reflects the counter value it sits alongside.
  always_comb begin
    stall_s     = bus.halt && !step_pending_r && (div_cnt_r == '0);
    step_rise_s = bus.step && !step_d_r;

    if (sync_r[1] && (hold_cnt_r != HOLD_MAX)) begin
      hold_next_s = hold_cnt_r + HW'(1);
    end else begin
      hold_next_s = hold_cnt_r;
    end
    rst_next_s = !(sync_r[1] && (hold_cnt_r == HOLD_MAX));

    if (rst_r || stall_s || (div_cnt_r == DIV_LAST)) begin
      div_next_s = '0;
    end else begin
      div_next_s = div_cnt_r + DW'(1);
    end

    // A step is only latched while parked at 0; it is consumed when leaving 0.
    if (rst_r) begin
      pending_next_s = 1'b0;
    end else if ((div_cnt_r == '0) && step_pending_r) begin
      pending_next_s = 1'b0;
    end else if (stall_s && step_rise_s) begin
      pending_next_s = 1'b1;
    end else begin
      pending_next_s = step_pending_r;
    end

    if (en_r) begin
      ctrl_next_s = (ctrl_cnt_r == CTRL_LAST) ? '0 : (ctrl_cnt_r + CW'(1));
    end else begin
      ctrl_next_s = ctrl_cnt_r;
    end

    if (en_r && (res_cnt_r != RES_MAX)) begin
      res_next_s = res_cnt_r + RW'(1);
    end else begin
      res_next_s = res_cnt_r;
    end

    en_next_s        = (div_next_s == DIV_LAST);
    phi2_next_s      = (div_next_s >= DIV_HALF);
    ctrl_en_next_s   = en_next_s && (ctrl_next_s == CTRL_LAST);
    cpu_res_b_next_s = (res_next_s == RES_MAX);
    running_next_s   = !rst_next_s &&
                       !((div_next_s == '0) && bus.halt && !pending_next_s);
  end

  // State and output registers.
  always_ff @(posedge clk_12_5875 or negedge rst_B) begin
    if (!rst_B) begin
      sync_r         <= 2'b00;
      hold_cnt_r     <= '0;
      rst_r          <= 1'b1;
      div_cnt_r      <= '0;
      step_d_r       <= 1'b0;
      step_pending_r <= 1'b0;
      ctrl_cnt_r     <= '0;
      res_cnt_r      <= '0;
      en_r           <= 1'b0;
      phi2_r         <= 1'b0;
      ctrl_en_r      <= 1'b0;
      cpu_res_b_r    <= 1'b0;
      running_r      <= 1'b0;
    end else begin
      sync_r         <= {sync_r[0], 1'b1};
      hold_cnt_r     <= hold_next_s;
      rst_r          <= rst_next_s;
      div_cnt_r      <= div_next_s;
      step_d_r       <= bus.step;
      step_pending_r <= pending_next_s;
      ctrl_cnt_r     <= ctrl_next_s;
      res_cnt_r      <= res_next_s;
      en_r           <= en_next_s;
      phi2_r         <= phi2_next_s;
      ctrl_en_r      <= ctrl_en_next_s;
      cpu_res_b_r    <= cpu_res_b_next_s;
      running_r      <= running_next_s;
    end
  end

  assign bus.cpu_clk_enable           = en_r;
  assign bus.phi2                     = phi2_r;
  assign bus.controller_clk_in_enable = ctrl_en_r;
  assign bus.rst                      = rst_r;
  assign bus.cpu_res_B                = cpu_res_b_r;
  assign bus.running                  = running_r;
endmodule
